// File: rtl/mem_burst_pkg.sv
// Shared definitions for the burst memory: FSM state encoding and the
// helpers that derive line geometry from the line-offset width.
package mem_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } state_t;

  localparam int WORD_WIDTH     = 32;
  localparam int WAIT_CNT_WIDTH = 6;

  // Number of 32-bit words in one line.
  function automatic int lineWords(input int offsetWidth);
    return 1 << offsetWidth;
  endfunction

  // Width in bits of one full line.
  function automatic int lineWidth(input int offsetWidth);
    return WORD_WIDTH * lineWords(offsetWidth);
  endfunction

endpackage

// File: rtl/mem_burst_ram.sv
// Single-port 32-bit synchronous RAM with per-byte write enables and a
// one-cycle registered read. Contents power up as all zero.
module mem_burst_ram #(
  parameter int ADDR_WIDTH = 14,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [3:0]            i_we,
  input  logic [31:0]           i_wData,
  output logic [31:0]           o_rData
);

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] r_rData;

  // Storage power-up image: all zero.
  initial begin
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) begin
      r_mem[i] = '0;
    end
  end

  // Byte-masked write and registered read; a read during a write returns
  // the old contents, which the controller never relies on.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wData[8*b +: 8];
      end
    end
    r_rData <= r_mem[i_addr];
  end

  assign o_rData = r_rData;

endmodule

// File: rtl/mem_burst.sv
// Line-oriented burst memory controller. Accepts one read or write line
// request at a time, waits LATENCY cycles, then moves the line one word
// per cycle through a single-port RAM and pulses mem_ready when done.
module mem_burst
  import mem_burst_pkg::*;
#(
  parameter int ADDR_WIDTH        = 14,
  parameter int LINE_OFFSET_WIDTH = 2,
  parameter int LATENCY           = 4,
  parameter     INIT_FILE         = "",
  localparam int LINE_WORDS       = lineWords(LINE_OFFSET_WIDTH),
  localparam int LINE_WIDTH       = lineWidth(LINE_OFFSET_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_r,
  input  logic                    mem_w,
  input  logic [31:0]             mem_addr,
  input  logic [LINE_WIDTH-1:0]   mem_w_data,
  input  logic [LINE_WIDTH/8-1:0] mem_be,
  output logic [LINE_WIDTH-1:0]   mem_r_data,
  output logic                    mem_ready,
  output logic                    mem_busy
);

  localparam int LINE_ADDR_WIDTH = ADDR_WIDTH - LINE_OFFSET_WIDTH;
  localparam logic [WAIT_CNT_WIDTH-1:0] LAST_WAIT =
    (LATENCY > 0) ? WAIT_CNT_WIDTH'(LATENCY - 1) : '0;
  localparam logic [LINE_OFFSET_WIDTH:0] LAST_XFER = (LINE_OFFSET_WIDTH+1)'(LINE_WORDS);

  state_t                         r_state;
  state_t                         w_nextState;
  logic [WAIT_CNT_WIDTH-1:0]      r_waitCnt;
  logic [LINE_OFFSET_WIDTH:0]     r_xferCnt;
  logic [LINE_ADDR_WIDTH-1:0]     r_lineAddr;
  logic [LINE_WIDTH-1:0]          r_wData;
  logic [LINE_WIDTH/8-1:0]        r_be;
  logic                           r_isWrite;
  logic [LINE_WIDTH-1:0]          r_rLine;

  logic                           w_request;
  logic [LINE_OFFSET_WIDTH-1:0]   w_wordIdx;
  logic [LINE_OFFSET_WIDTH-1:0]   w_prevIdx;
  logic                           w_addrPhase;
  logic [ADDR_WIDTH-1:0]          w_ramAddr;
  logic [3:0]                     w_ramWe;
  logic [31:0]                    w_ramWData;
  logic [31:0]                    w_ramRData;
  logic                           w_unusedAddr;

  assign w_request    = mem_r | mem_w;
  assign w_wordIdx    = r_xferCnt[LINE_OFFSET_WIDTH-1:0];
  assign w_prevIdx    = w_wordIdx - 1'b1;
  assign w_addrPhase  = (r_state == XFER) && !r_xferCnt[LINE_OFFSET_WIDTH];
  assign w_ramAddr    = {r_lineAddr, w_wordIdx};
  assign w_ramWData   = 32'(r_wData >> {w_wordIdx, 5'b00000});
  assign w_ramWe      = (w_addrPhase && r_isWrite && !rst)
                        ? 4'(r_be >> {w_wordIdx, 2'b00}) : 4'b0000;
  assign w_unusedAddr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[LINE_OFFSET_WIDTH+1:0]};

  assign mem_ready  = (r_state == DONE);
  assign mem_busy   = (r_state != IDLE);
  assign mem_r_data = (r_state == DONE && !r_isWrite) ? r_rLine : '0;

  mem_burst_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .i_addr  (w_ramAddr),
    .i_we    (w_ramWe),
    .i_wData (w_ramWData),
    .o_rData (w_ramRData)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: WAIT is skipped entirely when LATENCY is zero.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_request) begin
          w_nextState = (LATENCY == 0) ? XFER : WAIT;
        end
      end
      WAIT: begin
        if (r_waitCnt == LAST_WAIT) begin
          w_nextState = XFER;
        end
      end
      XFER: begin
        if (r_xferCnt == LAST_XFER) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Request capture, counters and read-line assembly; RAM data lags its
  // address by one cycle, so word k lands in the XFER cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_waitCnt  <= '0;
      r_xferCnt  <= '0;
      r_lineAddr <= '0;
      r_wData    <= '0;
      r_be       <= '0;
      r_isWrite  <= 1'b0;
      r_rLine    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_waitCnt <= '0;
          r_xferCnt <= '0;
          if (w_request) begin
            r_lineAddr <= mem_addr[ADDR_WIDTH+1 : LINE_OFFSET_WIDTH+2];
            r_wData    <= mem_w_data;
            r_be       <= mem_be;
            r_isWrite  <= mem_w;
            r_rLine    <= '0;
          end
        end
        WAIT: begin
          r_waitCnt <= r_waitCnt + 1'b1;
        end
        XFER: begin
          r_xferCnt <= r_xferCnt + 1'b1;
          if (!r_isWrite && (r_xferCnt != '0)) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
              if (w_prevIdx == LINE_OFFSET_WIDTH'(k)) begin
                r_rLine[32*k +: 32] <= w_ramRData;
              end
            end
          end
        end
        DONE: begin
          r_waitCnt <= '0;
          r_xferCnt <= '0;
        end
        default: begin
          r_waitCnt <= '0;
          r_xferCnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst.sv
// Directed bench for mem_burst: one instance with default parameters and
// one with LATENCY=0, driven from shared request signals.
module tb_mem_burst;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         reqR = 1'b0;
  logic         reqW = 1'b0;
  logic         selB = 1'b0;
  logic [31:0]  memAddr = '0;
  logic [127:0] wData = '0;
  logic [15:0]  be = '0;

  logic         aR, aW, bR, bW;
  logic [127:0] aRData, bRData;
  logic         aReady, bReady, aBusy, bBusy;

  logic         logReady [0:39];
  logic         logBusy  [0:39];
  logic [127:0] logRdata [0:39];
  int           readyCycle;
  int           readyCount;

  int checkCount = 0;
  int errorCount = 0;

  localparam logic [127:0] LINE1  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] MASKED = 128'h44444444_33333333_22222222_FFFFFFFF;
  localparam logic [127:0] LINE2  = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
  localparam logic [127:0] PRE3   = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] NEW3   = 128'h88888888_77777777_66666666_55555555;
  localparam logic [127:0] HALF3  = 128'hDDDDDDDD_CCCCCCCC_66666666_55555555;
  localparam logic [127:0] LINEB  = 128'h0BADF00D_12345678_9ABCDEF0_CAFEBABE;

  assign aR = reqR & ~selB;
  assign aW = reqW & ~selB;
  assign bR = reqR & selB;
  assign bW = reqW & selB;

  always #5 clk = ~clk;

  mem_burst dutA (
    .clk        (clk),
    .rst        (rst),
    .mem_r      (aR),
    .mem_w      (aW),
    .mem_addr   (memAddr),
    .mem_w_data (wData),
    .mem_be     (be),
    .mem_r_data (aRData),
    .mem_ready  (aReady),
    .mem_busy   (aBusy)
  );

  mem_burst #(.LATENCY(0)) dutB (
    .clk        (clk),
    .rst        (rst),
    .mem_r      (bR),
    .mem_w      (bW),
    .mem_addr   (memAddr),
    .mem_w_data (wData),
    .mem_be     (be),
    .mem_r_data (bRData),
    .mem_ready  (bReady),
    .mem_busy   (bBusy)
  );

  // Drives one request starting at cycle 0 and logs outputs each cycle at
  // the falling edge. Optionally swaps the address at changeAt and pulses
  // reset at rstAt. Stops one cycle after mem_ready or after maxCyc cycles.
  task automatic runRequest(input logic sel, input logic doW, input logic doR,
                            input logic [31:0] addr, input logic [127:0] data,
                            input logic [15:0] mask, input int changeAt,
                            input logic [31:0] altAddr, input int rstAt,
                            input int maxCyc);
    readyCycle = -1;
    readyCount = 0;
    for (int c = 0; c < 40; c++) begin
      logReady[c] = 1'b0;
      logBusy[c]  = 1'b0;
      logRdata[c] = '0;
    end
    @(negedge clk);
    selB = sel; memAddr = addr; wData = data; be = mask; reqW = doW; reqR = doR;
    for (int c = 0; c < maxCyc; c++) begin
      if (c > 0) @(negedge clk);
      logReady[c] = sel ? bReady : aReady;
      logBusy[c]  = sel ? bBusy  : aBusy;
      logRdata[c] = sel ? bRData : aRData;
      if (logReady[c] === 1'b1) begin
        readyCount++;
        if (readyCycle < 0) readyCycle = c;
        reqR = 1'b0; reqW = 1'b0;
      end
      if (c == changeAt) begin
        memAddr = altAddr; wData = ~data; be = ~mask;
      end
      if (c == rstAt) begin
        rst = 1'b1; reqR = 1'b0; reqW = 1'b0;
      end else if (c == rstAt + 1) begin
        rst = 1'b0;
      end
      if (readyCycle >= 0 && c == readyCycle + 1) break;
    end
    reqR = 1'b0; reqW = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (aReady !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_a_ready got %b want 0", aReady); end
    checkCount++;
    if (aBusy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_a_busy got %b want 0", aBusy); end
    checkCount++;
    if (aRData !== '0) begin errorCount++; $display("[TB] FAIL reset_a_rdata got %h want 0", aRData); end
    checkCount++;
    if (bReady !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_b_ready got %b want 0", bReady); end
    checkCount++;
    if (bBusy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_b_busy got %b want 0", bBusy); end
    rst = 1'b0;
  endtask

  task automatic test_write_line();
    runRequest(1'b0, 1'b1, 1'b0, 32'h100, LINE1, 16'hFFFF, -1, '0, -1, 30);
    checkCount++;
    if (readyCycle != 10) begin errorCount++; $display("[TB] FAIL write_ready_cycle got %0d want 10", readyCycle); end
    checkCount++;
    if (readyCount != 1) begin errorCount++; $display("[TB] FAIL write_ready_count got %0d want 1", readyCount); end
    checkCount++;
    if (logBusy[0] !== 1'b0) begin errorCount++; $display("[TB] FAIL write_busy_c0 got %b want 0", logBusy[0]); end
    for (int c = 1; c <= 9; c++) begin
      checkCount++;
      if (logBusy[c] !== 1'b1) begin errorCount++; $display("[TB] FAIL write_busy_c%0d got %b want 1", c, logBusy[c]); end
    end
    checkCount++;
    if (logBusy[11] !== 1'b0) begin errorCount++; $display("[TB] FAIL write_busy_c11 got %b want 0", logBusy[11]); end
    checkCount++;
    if (logRdata[10] !== '0) begin errorCount++; $display("[TB] FAIL write_rdata_c10 got %h want 0", logRdata[10]); end
  endtask

  task automatic test_read_line();
    runRequest(1'b0, 1'b0, 1'b1, 32'h100, '0, '0, -1, '0, -1, 30);
    checkCount++;
    if (readyCycle != 10) begin errorCount++; $display("[TB] FAIL read_ready_cycle got %0d want 10", readyCycle); end
    checkCount++;
    if (logRdata[10] !== LINE1) begin errorCount++; $display("[TB] FAIL read_data got %h want %h", logRdata[10], LINE1); end
    for (int c = 0; c <= 11; c++) begin
      if (c != 10) begin
        checkCount++;
        if (logRdata[c] !== '0) begin errorCount++; $display("[TB] FAIL read_rdata_c%0d got %h want 0", c, logRdata[c]); end
      end
    end
  endtask

  task automatic test_byte_mask();
    runRequest(1'b0, 1'b1, 1'b0, 32'h100, {128{1'b1}}, 16'h000F, -1, '0, -1, 30);
    checkCount++;
    if (readyCycle != 10) begin errorCount++; $display("[TB] FAIL mask_write_ready got %0d want 10", readyCycle); end
    runRequest(1'b0, 1'b0, 1'b1, 32'h100, '0, '0, -1, '0, -1, 30);
    checkCount++;
    if (logRdata[10] !== MASKED) begin errorCount++; $display("[TB] FAIL mask_read got %h want %h", logRdata[10], MASKED); end
  endtask

  task automatic test_addr_capture();
    runRequest(1'b0, 1'b1, 1'b0, 32'h200, LINE2, 16'hFFFF, -1, '0, -1, 30);
    runRequest(1'b0, 1'b0, 1'b1, 32'h100, '0, '0, 2, 32'h200, -1, 30);
    checkCount++;
    if (logRdata[10] !== MASKED) begin errorCount++; $display("[TB] FAIL addr_change_read got %h want %h", logRdata[10], MASKED); end
    runRequest(1'b0, 1'b0, 1'b1, 32'h200, '0, '0, -1, '0, -1, 30);
    checkCount++;
    if (logRdata[10] !== LINE2) begin errorCount++; $display("[TB] FAIL line2_read got %h want %h", logRdata[10], LINE2); end
    runRequest(1'b0, 1'b0, 1'b1, 32'h10100, '0, '0, -1, '0, -1, 30);
    checkCount++;
    if (logRdata[10] !== MASKED) begin errorCount++; $display("[TB] FAIL alias_read got %h want %h", logRdata[10], MASKED); end
  endtask

  task automatic test_reset_mid_xfer();
    runRequest(1'b0, 1'b1, 1'b0, 32'h300, PRE3, 16'hFFFF, -1, '0, -1, 30);
    runRequest(1'b0, 1'b1, 1'b0, 32'h300, NEW3, 16'hFFFF, -1, '0, 7, 16);
    checkCount++;
    if (readyCount != 0) begin errorCount++; $display("[TB] FAIL abort_ready_count got %0d want 0", readyCount); end
    checkCount++;
    if (logBusy[7] !== 1'b1) begin errorCount++; $display("[TB] FAIL abort_busy_c7 got %b want 1", logBusy[7]); end
    checkCount++;
    if (logBusy[8] !== 1'b0) begin errorCount++; $display("[TB] FAIL abort_idle_c8 got %b want 0", logBusy[8]); end
    runRequest(1'b0, 1'b0, 1'b1, 32'h300, '0, '0, -1, '0, -1, 30);
    checkCount++;
    if (logRdata[10] !== HALF3) begin errorCount++; $display("[TB] FAIL abort_read got %h want %h", logRdata[10], HALF3); end
  endtask

  task automatic test_latency0();
    runRequest(1'b1, 1'b1, 1'b1, 32'h40, LINEB, 16'hFFFF, -1, '0, -1, 30);
    checkCount++;
    if (readyCycle != 6) begin errorCount++; $display("[TB] FAIL lat0_write_ready got %0d want 6", readyCycle); end
    checkCount++;
    if (logRdata[6] !== '0) begin errorCount++; $display("[TB] FAIL lat0_write_rdata got %h want 0", logRdata[6]); end
    runRequest(1'b1, 1'b0, 1'b1, 32'h40, '0, '0, -1, '0, -1, 30);
    checkCount++;
    if (readyCycle != 6) begin errorCount++; $display("[TB] FAIL lat0_read_ready got %0d want 6", readyCycle); end
    checkCount++;
    if (logRdata[6] !== LINEB) begin errorCount++; $display("[TB] FAIL lat0_read got %h want %h", logRdata[6], LINEB); end
    checkCount++;
    if (logBusy[7] !== 1'b0) begin errorCount++; $display("[TB] FAIL lat0_busy_c7 got %b want 0", logBusy[7]); end
  endtask

  // Safety net so a stuck design still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got running want finished");
    $fatal(1, "[TB] timeout");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_write_line();
    test_read_line();
    test_byte_mask();
    test_addr_capture();
    test_reset_mid_xfer();
    test_latency0();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
